election_majority: RTL and testbench

- Seven-voter majority-decision block.
- Each cycle with a valid vote, it counts the asserted bits of the 7-bit ballot vector `people` and compares the count against a threshold.
- It outputs a registered pass/fail `result` plus the tally.
- Sits as a leaf decision unit, fed by a ballot-capture register and read by control/display logic.

---
 rtl/election_pkg.sv | 14 +
 rtl/election_majority_if.sv | 31 +++
 rtl/election_popcount.sv | 33 +++
 rtl/election_majority.sv | 91 +++++++++
 tb/tb_election_majority.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/election_pkg.sv
// Shared constants, types and helpers for the election majority block.
package election_pkg;

    localparam int N_VOTERS_DEF = 7;
    localparam int STAT_W       = 16;

    typedef logic [STAT_W-1:0] stat_t;

    // Width needed to hold a tally of 0..n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/election_majority_if.sv
// Ballot / decision bus between the ballot-capture register, the
// majority unit and the downstream control/display reader.
interface election_majority_if import election_pkg::*; #(
    parameter int N_VOTERS = N_VOTERS_DEF
) ();

    localparam int CW = count_width(N_VOTERS);

    logic [N_VOTERS-1:0] people;
    logic                vote_valid;
    logic                result;
    logic [CW-1:0]       vote_count;
    logic                result_valid;

    modport master (
        output people,
        output vote_valid,
        input  result,
        input  vote_count,
        input  result_valid
    );

    modport slave (
        input  people,
        input  vote_valid,
        output result,
        output vote_count,
        output result_valid
    );

endinterface

// File: rtl/election_popcount.sv
// Combinational population count of an N-bit vector. The seven-bit case
// uses a fixed two-level adder tree; other widths fall back to a loop.
module election_popcount import election_pkg::*; #(
    parameter int N  = N_VOTERS_DEF,
    parameter int CW = count_width(N)
) (
    input  logic [N-1:0]  vec,
    output logic [CW-1:0] count
);

    generate
        if (N == 7) begin : g_tree
            logic [1:0] grp_a_s;
            logic [1:0] grp_b_s;

            // Two three-input groups, then merge them with the odd bit.
            always_comb begin
                grp_a_s = {1'b0, vec[0]} + {1'b0, vec[1]} + {1'b0, vec[2]};
                grp_b_s = {1'b0, vec[3]} + {1'b0, vec[4]} + {1'b0, vec[5]};
                count   = {1'b0, grp_a_s} + {1'b0, grp_b_s} + {2'b00, vec[6]};
            end
        end else begin : g_loop
            // Generic accumulation, carried at the full tally width.
            always_comb begin
                count = '0;
                for (int i = 0; i < N; i++) begin
                    count = count + CW'(vec[i]);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/election_majority.sv
// Seven-voter (parameterisable) majority decision unit with a one-cycle
// registered result and tally. Optional pass/fail statistics counters are
// compiled in when ELECTION_STATS_EN is defined.
module election_majority import election_pkg::*; #(
    parameter int N_VOTERS  = N_VOTERS_DEF,
    parameter int THRESHOLD = (N_VOTERS / 2) + 1
) (
    input  logic                clk,
    input  logic                rst,
    election_majority_if.slave  bus
`ifdef ELECTION_STATS_EN
    ,
    output stat_t               pass_total,
    output stat_t               fail_total
`endif
);

    localparam int CW = count_width(N_VOTERS);
    localparam logic [CW-1:0] THR_C = CW'(THRESHOLD);

    generate
        if ((THRESHOLD < 1) || (THRESHOLD > N_VOTERS)) begin : g_bad_threshold
            $fatal(1, "election_majority: THRESHOLD out of range 1..N_VOTERS");
        end
    endgenerate

    logic [CW-1:0] count_next_s;
    logic          result_next_s;
    logic [CW-1:0] vote_count_r;
    logic          result_r;
    logic          result_valid_r;

    election_popcount #(
        .N  (N_VOTERS),
        .CW (CW)
    ) u_popcount (
        .vec   (bus.people),
        .count (count_next_s)
    );

    // Threshold decision on the live tally.
    always_comb begin
        result_next_s = (count_next_s >= THR_C);
    end

    // Capture the decision on a valid ballot; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r       <= 1'b0;
            vote_count_r   <= '0;
            result_valid_r <= 1'b0;
        end else if (bus.vote_valid) begin
            result_r       <= result_next_s;
            vote_count_r   <= count_next_s;
            result_valid_r <= 1'b1;
        end else begin
            result_valid_r <= 1'b0;
        end
    end

    assign bus.result       = result_r;
    assign bus.vote_count   = vote_count_r;
    assign bus.result_valid = result_valid_r;

`ifdef ELECTION_STATS_EN
    stat_t pass_total_r;
    stat_t fail_total_r;

    // Saturating pass/fail tallies, updated alongside the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_total_r <= '0;
            fail_total_r <= '0;
        end else if (bus.vote_valid) begin
            if (result_next_s) begin
                if (pass_total_r != {STAT_W{1'b1}}) begin
                    pass_total_r <= pass_total_r + stat_t'(1);
                end
            end else begin
                if (fail_total_r != {STAT_W{1'b1}}) begin
                    fail_total_r <= fail_total_r + stat_t'(1);
                end
            end
        end
    end

    assign pass_total = pass_total_r;
    assign fail_total = fail_total_r;
`endif

endmodule

// File: tb/tb_election_majority.sv
// Scoreboard bench for election_majority: expected tally/decision pairs
// are queued as ballots are driven and retired on each result strobe.
module tb_election_majority;
    import election_pkg::*;

    localparam int N  = 7;
    localparam int CW = count_width(N);

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          res;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   total_cnt;
    int   bad_cnt;

    election_majority_if #(.N_VOTERS(N)) bus ();

`ifdef ELECTION_STATS_EN
    stat_t pass_total;
    stat_t fail_total;
`endif

    election_majority #(.N_VOTERS(N), .THRESHOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef ELECTION_STATS_EN
        ,
        .pass_total (pass_total),
        .fail_total (fail_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one valid ballot at a negedge and queue its expected outcome.
    task automatic vote(input logic [N-1:0] p);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < N; i++) ones += int'(p[i]);
        e.cnt = CW'(ones);
        e.res = (ones >= 4);
        bus.people     = p;
        bus.vote_valid = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Idle cycle with garbage or X on the ballot lines.
    task automatic idle(input bit use_x);
        bus.vote_valid = 1'b0;
        bus.people     = use_x ? 'x : N'($urandom);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [CW-1:0] c, input logic r, input logic v);
        chk({tag, ".count"}, 32'(bus.vote_count), 32'(c));
        chk({tag, ".result"}, 32'(bus.result), 32'(r));
        chk({tag, ".valid"}, 32'(bus.result_valid), 32'(v));
    endtask

    // Retire one expectation per result strobe.
    always @(negedge clk) begin
        exp_t e;
        if (bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb.unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb.count", 32'(bus.vote_count), 32'(e.cnt));
                chk("sb.result", 32'(bus.result), 32'(e.res));
            end
        end
    end

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst            = 1'b1;
        bus.people     = 7'b1111111;
        bus.vote_valid = 1'b1;
        @(negedge clk);
        chk_out("rst1", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("rst2", 3'd0, 1'b0, 1'b0);
        rst            = 1'b0;
        bus.vote_valid = 1'b0;

        vote(7'b0011111);
        chk_out("five", 3'd5, 1'b1, 1'b1);
        idle(1'b0);
        chk_out("five.hold", 3'd5, 1'b1, 1'b0);

        vote(7'b0000001);
        vote(7'b0000000);
        chk_out("zero", 3'd0, 1'b0, 1'b1);
        idle(1'b0);
        chk_out("zero.hold", 3'd0, 1'b0, 1'b0);

        vote(7'b0000111);
        chk_out("thr3", 3'd3, 1'b0, 1'b1);
        vote(7'b1001011);
        chk_out("thr4", 3'd4, 1'b1, 1'b1);
        vote(7'b1111111);
        chk_out("all7", 3'd7, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            idle(i[0]);
            chk_out("idle.hold", 3'd7, 1'b1, 1'b0);
        end

        rst            = 1'b1;
        bus.people     = 7'b1111111;
        bus.vote_valid = 1'b1;
        @(negedge clk);
        chk_out("midrst", 3'd0, 1'b0, 1'b0);
        rst            = 1'b0;
        bus.vote_valid = 1'b0;
        idle(1'b0);
        chk_out("midrst.hold", 3'd0, 1'b0, 1'b0);

`ifdef ELECTION_STATS_EN
        chk("stats.rst.pass", 32'(pass_total), 32'(0));
        chk("stats.rst.fail", 32'(fail_total), 32'(0));
        vote(7'b1111000);
        vote(7'b0000011);
        vote(7'b1110001);
        vote(7'b1000000);
        vote(7'b0111111);
        chk("stats.pass", 32'(pass_total), 32'(3));
        chk("stats.fail", 32'(fail_total), 32'(2));
        for (int i = 0; i < 65535; i++) vote(7'b1111111);
        chk("stats.pass.sat", 32'(pass_total), 32'(16'hFFFF));
        vote(7'b0000000);
        chk("stats.fail.after", 32'(fail_total), 32'(3));
        vote(7'b1111111);
        chk("stats.pass.stick", 32'(pass_total), 32'(16'hFFFF));
        idle(1'b0);
`endif

        idle(1'b0);
        chk("sb.drain", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
